// File: rtl/noc_axi_mem_slave_if.sv
// rtl/noc_axi_mem_slave_if.sv - AXI4 bus bundle between an xbar master port and the memory endpoint
// Ports (signals): AW aw_id/aw_addr/aw_len/aw_size/aw_burst/aw_valid/aw_ready,
//   W w_data/w_strb/w_last/w_valid/w_ready, B b_id/b_resp/b_valid/b_ready,
//   AR ar_id/ar_addr/ar_len/ar_size/ar_burst/ar_valid/ar_ready,
//   R r_id/r_data/r_resp/r_last/r_valid/r_ready.
// Modports: master drives requests, slave drives responses.
interface noc_axi_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic                    w_valid;
  logic                    w_ready;

  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;

  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/noc_axi_mem_slave.sv
// rtl/noc_axi_mem_slave.sv - single-outstanding AXI4 memory endpoint
// Ports: clk_i  - block clock, rising edge
//        rst_i  - asynchronous active-high reset
//        s_axi  - noc_axi_mem_slave_if.slave, AW/W/B/AR/R channels
// One transaction at a time: IDLE arbitrates AW vs AR (alternating on ties),
// WR_DATA absorbs beats, WR_RESP returns B, RD_DATA streams R beats.
module noc_axi_mem_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  noc_axi_mem_slave_if.slave     s_axi
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam int MEM_AW   = IDX_W + ADDR_LSB;

  localparam logic [2:0]            FULL_SIZE   = 3'(ADDR_LSB);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES  = ADDR_WIDTH'(STRB_W);
  localparam logic [1:0]            BURST_FIXED = 2'b00;
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;
  localparam logic [1:0]            RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_e;

  state_e                  state_q, state_d;
  logic                    last_rd_q, last_rd_d;    // last grant went to the read side
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;          // address of the current beat
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    fixed_q, fixed_d;        // FIXED burst: address never advances
  logic                    perr_q, perr_d;          // WRAP/reserved burst or narrow size
  logic                    dec_err_q, dec_err_d;    // some write beat fell outside memory
  logic                    last_err_q, last_err_d;  // w_last not aligned with aw_len
  logic [1:0]              b_resp_q, b_resp_d;
  logic [DATA_WIDTH-1:0]   r_data_q, r_data_d;
  logic [1:0]              r_resp_q, r_resp_d;
  logic                    r_last_q, r_last_d;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic                    wr_grant, rd_grant;
  logic                    aw_perr, ar_perr;
  logic                    final_beat;
  logic [7:0]              cnt_inc;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    mem_we;

  // BASE_ADDR is aligned to the memory size, so range is a compare of the upper bits.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:MEM_AW] == BASE_ADDR[ADDR_WIDTH-1:MEM_AW];
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[MEM_AW-1:ADDR_LSB];
  endfunction

  function automatic logic proto_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != FULL_SIZE) || burst[1];
  endfunction

  function automatic logic [1:0] beat_resp(input logic rng_ok, input logic perr);
    if (!rng_ok) return RESP_DECERR;
    if (perr)    return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // Arbitration: write wins a tie only when the previous grant was a read.
  assign wr_grant = s_axi.aw_valid && (!s_axi.ar_valid || last_rd_q);
  assign rd_grant = s_axi.ar_valid && !wr_grant;

  assign s_axi.aw_ready = (state_q == IDLE) && !rst_i && wr_grant;
  assign s_axi.ar_ready = (state_q == IDLE) && !rst_i && rd_grant;
  assign s_axi.w_ready  = (state_q == WR_DATA);
  assign s_axi.b_valid  = (state_q == WR_RESP);
  assign s_axi.b_id     = id_q;
  assign s_axi.b_resp   = b_resp_q;
  assign s_axi.r_valid  = (state_q == RD_DATA);
  assign s_axi.r_id     = id_q;
  assign s_axi.r_data   = r_data_q;
  assign s_axi.r_resp   = r_resp_q;
  assign s_axi.r_last   = r_last_q;

  assign aw_perr    = proto_err(s_axi.aw_size, s_axi.aw_burst);
  assign ar_perr    = proto_err(s_axi.ar_size, s_axi.ar_burst);
  assign final_beat = (cnt_q == len_q);
  assign cnt_inc    = cnt_q + 8'd1;
  assign addr_nxt   = fixed_q ? addr_q : addr_q + BEAT_BYTES;

  // The R register is loaded one beat ahead: from ar_addr on the AR handshake,
  // from the following address on each R handshake.
  assign rd_addr = (state_q == IDLE) ? s_axi.ar_addr : addr_nxt;
  assign rd_word = in_range(rd_addr) ? mem[word_idx(rd_addr)] : '0;

  always_comb begin
    state_d    = state_q;
    last_rd_d  = last_rd_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    fixed_d    = fixed_q;
    perr_d     = perr_q;
    dec_err_d  = dec_err_q;
    last_err_d = last_err_q;
    b_resp_d   = b_resp_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    r_last_d   = r_last_q;
    mem_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_axi.aw_ready) begin
          id_d       = s_axi.aw_id;
          addr_d     = s_axi.aw_addr;
          len_d      = s_axi.aw_len;
          cnt_d      = 8'd0;
          fixed_d    = (s_axi.aw_burst == BURST_FIXED);
          perr_d     = aw_perr;
          dec_err_d  = 1'b0;
          last_err_d = 1'b0;
          last_rd_d  = 1'b0;
          state_d    = WR_DATA;
        end else if (s_axi.ar_ready) begin
          id_d      = s_axi.ar_id;
          addr_d    = s_axi.ar_addr;
          len_d     = s_axi.ar_len;
          cnt_d     = 8'd0;
          fixed_d   = (s_axi.ar_burst == BURST_FIXED);
          perr_d    = ar_perr;
          last_rd_d = 1'b1;
          r_data_d  = rd_word;
          r_resp_d  = beat_resp(in_range(s_axi.ar_addr), ar_perr);
          r_last_d  = (s_axi.ar_len == 8'd0);
          state_d   = RD_DATA;
        end
      end

      WR_DATA: begin
        if (s_axi.w_valid) begin
          mem_we     = in_range(addr_q);
          dec_err_d  = dec_err_q | !in_range(addr_q);
          last_err_d = last_err_q | (s_axi.w_last != final_beat);
          addr_d     = addr_nxt;
          cnt_d      = cnt_inc;
          // The burst length, not w_last, decides where the write ends.
          if (final_beat) begin
            if (dec_err_d)                b_resp_d = RESP_DECERR;
            else if (last_err_d || perr_q) b_resp_d = RESP_SLVERR;
            else                           b_resp_d = RESP_OKAY;
            state_d = WR_RESP;
          end
        end
      end

      WR_RESP: begin
        if (s_axi.b_ready) state_d = IDLE;
      end

      RD_DATA: begin
        if (s_axi.r_ready) begin
          if (r_last_q) begin
            r_last_d = 1'b0;
            state_d  = IDLE;
          end else begin
            addr_d   = addr_nxt;
            cnt_d    = cnt_inc;
            r_data_d = rd_word;
            r_resp_d = beat_resp(in_range(addr_nxt), perr_q);
            r_last_d = (cnt_inc == len_q);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      last_rd_q  <= 1'b1;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      fixed_q    <= 1'b0;
      perr_q     <= 1'b0;
      dec_err_q  <= 1'b0;
      last_err_q <= 1'b0;
      b_resp_q   <= '0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
      r_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_rd_q  <= last_rd_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      fixed_q    <= fixed_d;
      perr_q     <= perr_d;
      dec_err_q  <= dec_err_d;
      last_err_q <= last_err_d;
      b_resp_q   <= b_resp_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      r_last_q   <= r_last_d;
    end
  end

  // Storage is deliberately not reset; mem_we is already low while rst_i holds
  // the FSM in IDLE.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.w_strb[b]) mem[word_idx(addr_q)][b*8 +: 8] <= s_axi.w_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_noc_axi_mem_slave.sv
// tb/tb_noc_axi_mem_slave.sv - directed self-checking bench for noc_axi_mem_slave
module tb_noc_axi_mem_slave;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  logic clk;
  logic rst_i;
  int   n_checks = 0;
  int   n_fail   = 0;

  noc_axi_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)) axi_bus ();

  noc_axi_mem_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4), .MEM_DEPTH(256), .BASE_ADDR(BASE)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .s_axi (axi_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    axi_bus.aw_id = id; axi_bus.aw_addr = addr; axi_bus.aw_len = len;
    axi_bus.aw_size = size; axi_bus.aw_burst = burst; axi_bus.aw_valid = 1'b1;
    #1;
    while (!axi_bus.aw_ready && n < 50) begin @(posedge clk); #1; n++; end
    check_eq("aw_accept", axi_bus.aw_ready, 1'b1);
    @(posedge clk); #1;
    axi_bus.aw_valid = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    axi_bus.ar_id = id; axi_bus.ar_addr = addr; axi_bus.ar_len = len;
    axi_bus.ar_size = size; axi_bus.ar_burst = burst; axi_bus.ar_valid = 1'b1;
    #1;
    while (!axi_bus.ar_ready && n < 50) begin @(posedge clk); #1; n++; end
    check_eq("ar_accept", axi_bus.ar_ready, 1'b1);
    @(posedge clk); #1;
    axi_bus.ar_valid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    axi_bus.w_data = data; axi_bus.w_strb = strb; axi_bus.w_last = last; axi_bus.w_valid = 1'b1;
    #1;
    while (!axi_bus.w_ready && n < 50) begin @(posedge clk); #1; n++; end
    check_eq("w_accept", axi_bus.w_ready, 1'b1);
    @(posedge clk); #1;
    axi_bus.w_valid = 1'b0;
  endtask

  task automatic b_expect(input string tag, input logic [3:0] id, input logic [1:0] resp);
    int n = 0;
    axi_bus.b_ready = 1'b1;
    while (!axi_bus.b_valid && n < 50) begin @(posedge clk); #1; n++; end
    check_eq({tag, "_bvalid"}, axi_bus.b_valid, 1'b1);
    check_eq({tag, "_bid"}, axi_bus.b_id, id);
    check_eq({tag, "_bresp"}, axi_bus.b_resp, resp);
    @(posedge clk); #1;
    axi_bus.b_ready = 1'b0;
  endtask

  task automatic r_expect(input string tag, input logic [63:0] data, input logic [1:0] resp,
                          input logic last, input logic [3:0] id);
    int n = 0;
    axi_bus.r_ready = 1'b1;
    while (!axi_bus.r_valid && n < 50) begin @(posedge clk); #1; n++; end
    check_eq({tag, "_rvalid"}, axi_bus.r_valid, 1'b1);
    check_eq({tag, "_rdata"}, axi_bus.r_data, data);
    check_eq({tag, "_rresp"}, axi_bus.r_resp, resp);
    check_eq({tag, "_rlast"}, axi_bus.r_last, last);
    check_eq({tag, "_rid"}, axi_bus.r_id, id);
    @(posedge clk); #1;
    axi_bus.r_ready = 1'b0;
  endtask

  task automatic wr1(input string tag, input logic [31:0] addr, input logic [63:0] data,
                     input logic [7:0] strb);
    aw_send(4'd1, addr, 8'd0, 3'd3, 2'b01);
    w_beat(data, strb, 1'b1);
    b_expect(tag, 4'd1, OKAY);
  endtask

  task automatic rd1(input string tag, input logic [31:0] addr, input logic [63:0] data,
                     input logic [1:0] resp);
    ar_send(4'd2, addr, 8'd0, 3'd3, 2'b01);
    r_expect(tag, data, resp, 1'b1, 4'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    axi_bus.aw_valid = 0; axi_bus.w_valid = 0; axi_bus.b_ready = 0;
    axi_bus.ar_valid = 0; axi_bus.r_ready = 0;
    axi_bus.w_data = '0; axi_bus.w_strb = '0; axi_bus.w_last = 0;
    // Tie request for the first write/read pair, present already during reset.
    axi_bus.aw_id = 4'd3; axi_bus.aw_addr = BASE + 32'h10; axi_bus.aw_len = 8'd3;
    axi_bus.aw_size = 3'd3; axi_bus.aw_burst = 2'b01;
    axi_bus.ar_id = 4'd3; axi_bus.ar_addr = BASE + 32'h10; axi_bus.ar_len = 8'd3;
    axi_bus.ar_size = 3'd3; axi_bus.ar_burst = 2'b01;
    axi_bus.aw_valid = 1'b1; axi_bus.ar_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_aw_ready", axi_bus.aw_ready, 1'b0);
    check_eq("rst_ar_ready", axi_bus.ar_ready, 1'b0);
    check_eq("rst_w_ready", axi_bus.w_ready, 1'b0);
    check_eq("rst_b_valid", axi_bus.b_valid, 1'b0);
    check_eq("rst_r_valid", axi_bus.r_valid, 1'b0);
    check_eq("rst_r_last", axi_bus.r_last, 1'b0);
    check_eq("rst_b_resp", axi_bus.b_resp, 2'b00);
    check_eq("rst_r_resp", axi_bus.r_resp, 2'b00);
    check_eq("rst_r_data", axi_bus.r_data, 64'h0);
    check_eq("rst_b_id", axi_bus.b_id, 4'd0);
    check_eq("rst_r_id", axi_bus.r_id, 4'd0);

    // First tie after reset: write wins.
    rst_i = 1'b0;
    #1;
    check_eq("tie1_aw_ready", axi_bus.aw_ready, 1'b1);
    check_eq("tie1_ar_ready", axi_bus.ar_ready, 1'b0);
    @(posedge clk); #1;
    axi_bus.aw_valid = 1'b0;
    check_eq("wr_w_ready", axi_bus.w_ready, 1'b1);
    check_eq("wr_ar_blocked", axi_bus.ar_ready, 1'b0);
    for (int i = 1; i <= 4; i++) w_beat(64'(i), 8'hff, i == 4);
    check_eq("wresp_ar_blocked", axi_bus.ar_ready, 1'b0);
    b_expect("b033", 4'd3, OKAY);
    // Pending AR is granted straight after B.
    check_eq("ar_after_b", axi_bus.ar_ready, 1'b1);
    check_eq("rvalid_in_ar_cycle", axi_bus.r_valid, 1'b0);
    @(posedge clk); #1;
    axi_bus.ar_valid = 1'b0;
    check_eq("rvalid_after_ar", axi_bus.r_valid, 1'b1);
    for (int i = 1; i <= 4; i++) r_expect("r033", 64'(i), OKAY, i == 4, 4'd3);

    // Second tie (last grant read): write wins; third tie (last grant write): read wins.
    axi_bus.aw_id = 4'd5; axi_bus.aw_addr = BASE + 32'h100; axi_bus.aw_len = 8'd0;
    axi_bus.aw_size = 3'd3; axi_bus.aw_burst = 2'b01;
    axi_bus.ar_id = 4'd6; axi_bus.ar_addr = BASE + 32'h100; axi_bus.ar_len = 8'd0;
    axi_bus.ar_size = 3'd3; axi_bus.ar_burst = 2'b01;
    axi_bus.aw_valid = 1'b1; axi_bus.ar_valid = 1'b1;
    #1;
    check_eq("tie2_aw_ready", axi_bus.aw_ready, 1'b1);
    check_eq("tie2_ar_ready", axi_bus.ar_ready, 1'b0);
    @(posedge clk); #1;
    axi_bus.aw_valid = 1'b0;
    w_beat(64'hAA, 8'hff, 1'b1);
    b_expect("b_tie2", 4'd5, OKAY);
    axi_bus.aw_valid = 1'b1;
    #1;
    check_eq("tie3_ar_ready", axi_bus.ar_ready, 1'b1);
    check_eq("tie3_aw_ready", axi_bus.aw_ready, 1'b0);
    @(posedge clk); #1;
    axi_bus.ar_valid = 1'b0; axi_bus.aw_valid = 1'b0;
    r_expect("r_tie3", 64'hAA, OKAY, 1'b1, 4'd6);

    // Out-of-range write must not alias onto word 0.
    wr1("pre0", BASE, 64'h55, 8'hff);
    aw_send(4'd7, BASE + 32'h800, 8'd0, 3'd3, 2'b01);
    w_beat(64'hDEAD, 8'hff, 1'b1);
    b_expect("b_oor", 4'd7, DECERR);
    rd1("r_word0", BASE, 64'h55, OKAY);
    rd1("r_oor", BASE + 32'h800, 64'h0, DECERR);

    // Early w_last: both beats land, B SLVERR.
    aw_send(4'd8, BASE + 32'h40, 8'd1, 3'd3, 2'b01);
    w_beat(64'h11, 8'hff, 1'b1);
    w_beat(64'h22, 8'hff, 1'b0);
    b_expect("b_early_last", 4'd8, SLVERR);
    ar_send(4'd9, BASE + 32'h40, 8'd1, 3'd3, 2'b01);
    r_expect("r_early0", 64'h11, OKAY, 1'b0, 4'd9);
    r_expect("r_early1", 64'h22, OKAY, 1'b1, 4'd9);

    // FIXED burst: only the final beat survives, neighbour untouched.
    wr1("pre88", BASE + 32'h88, 64'h77, 8'hff);
    aw_send(4'd10, BASE + 32'h80, 8'd3, 3'd3, 2'b00);
    for (int i = 1; i <= 4; i++) w_beat(64'hA0 + 64'(i), 8'hff, i == 4);
    b_expect("b_fixed", 4'd10, OKAY);
    ar_send(4'd11, BASE + 32'h80, 8'd1, 3'd3, 2'b01);
    r_expect("r_fixed0", 64'hA4, OKAY, 1'b0, 4'd11);
    r_expect("r_fixed1", 64'h77, OKAY, 1'b1, 4'd11);

    // Byte strobes, then a narrow-size read (SLVERR, full-width data).
    wr1("strb", BASE + 32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0f);
    ar_send(4'd12, BASE + 32'h10, 8'd0, 3'd2, 2'b01);
    r_expect("r_narrow", 64'h0000_0000_FFFF_FFFF, SLVERR, 1'b1, 4'd12);

    // WRAP burst runs as INCR with SLVERR.
    aw_send(4'd13, BASE + 32'h200, 8'd1, 3'd3, 2'b10);
    w_beat(64'hC1, 8'hff, 1'b0);
    w_beat(64'hC2, 8'hff, 1'b1);
    b_expect("b_wrap", 4'd13, SLVERR);
    ar_send(4'd14, BASE + 32'h200, 8'd1, 3'd3, 2'b10);
    r_expect("r_wrap0", 64'hC1, SLVERR, 1'b0, 4'd14);
    r_expect("r_wrap1", 64'hC2, SLVERR, 1'b1, 4'd14);

    // R backpressure for 5 cycles mid-burst.
    ar_send(4'd14, BASE + 32'h10, 8'd3, 3'd3, 2'b01);
    r_expect("r_bp0", 64'h0000_0000_FFFF_FFFF, OKAY, 1'b0, 4'd14);
    for (int k = 0; k < 5; k++) begin
      check_eq("bp_rvalid", axi_bus.r_valid, 1'b1);
      check_eq("bp_rdata", axi_bus.r_data, 64'h2);
      check_eq("bp_rlast", axi_bus.r_last, 1'b0);
      @(posedge clk); #1;
    end
    r_expect("r_bp1", 64'h2, OKAY, 1'b0, 4'd14);
    r_expect("r_bp2", 64'h3, OKAY, 1'b0, 4'd14);
    r_expect("r_bp3", 64'h4, OKAY, 1'b1, 4'd14);

    // B backpressure for 3 cycles with a new AW waiting.
    aw_send(4'd15, BASE + 32'h400, 8'd0, 3'd3, 2'b01);
    w_beat(64'h99, 8'hff, 1'b1);
    axi_bus.aw_addr = BASE + 32'h408; axi_bus.aw_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("bhold_bvalid", axi_bus.b_valid, 1'b1);
      check_eq("bhold_aw_ready", axi_bus.aw_ready, 1'b0);
      @(posedge clk); #1;
    end
    axi_bus.aw_valid = 1'b0;
    b_expect("b_hold", 4'd15, OKAY);

    // Reset during beat 2 of a len=3 write.
    aw_send(4'd1, BASE + 32'h300, 8'd3, 3'd3, 2'b01);
    w_beat(64'hB1, 8'hff, 1'b0);
    axi_bus.w_data = 64'hB2; axi_bus.w_valid = 1'b1;
    rst_i = 1'b1;
    #1;
    check_eq("mid_rst_w_ready", axi_bus.w_ready, 1'b0);
    check_eq("mid_rst_aw_ready", axi_bus.aw_ready, 1'b0);
    check_eq("mid_rst_b_valid", axi_bus.b_valid, 1'b0);
    check_eq("mid_rst_r_valid", axi_bus.r_valid, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_i = 1'b0;
    axi_bus.w_valid = 1'b0;
    wr1("post_rst", BASE + 32'h310, 64'h5A, 8'hff);
    rd1("r_beat1_kept", BASE + 32'h300, 64'hB1, OKAY);
    rd1("r_post_rst", BASE + 32'h310, 64'h5A, OKAY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_axi_mem_slave.md
NOC_AXI_MEM_SLAVE -- requirements
Module: noc_axi_mem_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AXI address width in bits.
REQ-002 Parameter DATA_WIDTH, default 64, AXI data width in bits; legal values 32 and 64.
REQ-003 Parameter ID_WIDTH, default 4, AXI ID width in bits.
REQ-004 Parameter MEM_DEPTH, default 256, number of DATA_WIDTH words; power of two.
REQ-005 Parameter BASE_ADDR, default 0, byte address of word 0; aligned to MEM_DEPTH*DATA_WIDTH/8.
REQ-006 clk_i  in  1  block clock; all state changes on its rising edge.
REQ-007 rst_i  in  1  reset, asynchronous assert, active-high.
REQ-008 aw_id/aw_addr/aw_len(8)/aw_size(3)/aw_burst(2)/aw_valid  in; aw_ready  out: AXI4 write address channel from an xbar master port.
REQ-009 w_data/w_strb(DATA_WIDTH/8)/w_last/w_valid  in; w_ready  out: write data channel.
REQ-010 b_id/b_resp(2)/b_valid  out; b_ready  in: write response channel.
REQ-011 ar_id/ar_addr/ar_len/ar_size/ar_burst/ar_valid  in; ar_ready  out: read address channel.
REQ-012 r_id/r_data/r_resp(2)/r_last/r_valid  out; r_ready  in: read data channel.

Function
REQ-013 The block SHALL be a single-outstanding AXI4 memory endpoint with FSM states IDLE, WR_DATA, WR_RESP and RD_DATA.
REQ-014 In IDLE, write is granted when aw_valid and (not ar_valid or last grant was read); otherwise read is granted when ar_valid.
REQ-015 aw_ready SHALL be 1 only in IDLE with write granted; ar_ready only in IDLE with read granted; both are combinational from state, valids and last-grant flag.
REQ-016 AW handshake: capture id, addr, len, burst, clear beat counter, set last grant=write, go to WR_DATA.
REQ-017 AR handshake: capture fields, set last grant=read, go to RD_DATA; r_valid first asserts the cycle after the AR handshake.
REQ-018 w_ready SHALL be 1 throughout WR_DATA; each W handshake writes the bytes enabled by w_strb to the current word if the address is in range.
REQ-019 Address in range when BASE_ADDR <= addr < BASE_ADDR + MEM_DEPTH*DATA_WIDTH/8; word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8).
REQ-020 After each accepted beat, INCR (01) advances the address by DATA_WIDTH/8 modulo 2^ADDR_WIDTH; FIXED (00) holds it.
REQ-021 Burst types WRAP (10) and reserved (11) SHALL be executed as INCR with response SLVERR (10) on every beat and in B.
REQ-022 aw_size/ar_size other than log2(DATA_WIDTH/8) SHALL be executed as full-width beats with SLVERR.
REQ-023 WR_DATA ends on the beat where counter == aw_len, regardless of w_last; go to WR_RESP.
REQ-024 b_resp priority: DECERR (11) if any beat out of range, else SLVERR if w_last low on the final beat, high on an earlier beat, or per REQ-021/022, else OKAY (00).
REQ-025 Out-of-range write beats SHALL NOT modify memory.
REQ-026 WR_RESP: b_valid=1, b_id=captured id; on b_ready go to IDLE; b_valid stays high until accepted.
REQ-027 RD_DATA: r_data registered from the current word, r_id=captured id, r_last=1 when counter == ar_len, r_resp per beat (DECERR out of range with r_data=0, else SLVERR per REQ-021/022, else OKAY).
REQ-028 r_data/r_resp/r_last SHALL be held stable while r_valid and not r_ready; next beat presented the cycle after each handshake (back-to-back beats at full rate).
REQ-029 On the r_last handshake, go to IDLE; a new AW/AR may be accepted the following cycle.
REQ-030 Writes and reads never overlap; a read issued after a write's B handshake SHALL return the written data.

Reset
REQ-031 While rst_i=1: state IDLE, last grant=read (write wins first tie), aw_ready/ar_ready/w_ready/b_valid/r_valid/r_last=0, b_resp/r_resp/r_data/ids=0.
REQ-032 Memory contents are not reset; reset mid-burst aborts the transaction with no B/R response issued, and words already written keep their data.

Verification
REQ-033 AW id=3 addr=BASE+0x10 len=3 INCR, 4 W beats strb=all-ones data 1..4, w_last on beat 4 -> one B id=3 OKAY; AR same -> 4 R beats 1..4, r_last on beat 4 only, r_valid first cycle after AR.
REQ-034 AW and AR valid in the same cycle after reset -> AW accepted first; after B, AR accepted; repeat tie -> write wins again only after a read grant.
REQ-035 Write len=0 addr=BASE+MEM_DEPTH*8 (64-bit) -> memory unchanged, B DECERR; read same -> r_data=0, r_resp DECERR, r_last=1.
REQ-036 Write len=1 with w_last on beat 1 -> both beats written, B SLVERR; FIXED burst len=3 -> only last beat data remains at the address.
REQ-037 r_ready held low 5 cycles mid-burst -> r_data/r_last stable; b_ready low 3 cycles -> b_valid held, no new AW accepted.
REQ-038 rst_i asserted during beat 2 of a len=3 write -> all valid/ready outputs low immediately, beat 1 retained, first post-reset AW accepted normally.
